wb_arbiter: RTL and testbench

Writeback arbiter that drives the single register-file write port (we / rd_index / rd_write).
- Merges the in-order pipeline writeback with results from long-latency units (divider, uncached load) via a small FIFO.
- Suppresses r0 writes, since the register file does not protect r0.
- Exports a pending-destination mask so issue logic can hold dependent instructions.

---
 rtl/wb_arbiter_pkg.sv | 25 ++
 rtl/wb_arbiter_if.sv | 49 ++++
 rtl/wb_fifo.sv | 73 +++++++
 rtl/wb_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_wb_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the writeback arbiter.
// The request record carries a pc field only when WB_TRACE_EN is defined.
// Without the trace build the record is 37 bits wide.
package wb_arbiter_pkg;

  localparam int         REG_NUM = 32;
  localparam logic [4:0] R0      = 5'd0;

  // One writeback request as it travels through the long-latency FIFO.
  typedef struct packed {
`ifdef WB_TRACE_EN
    logic [31:0] pc;
`endif
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_req_t;

  // Source that owns the register-file write port in a given cycle.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_PIPE = 2'd1,
    SEL_LL   = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the writeback producers, the arbiter and the register
// file. The slave modport is the arbiter's view; master is the environment.
// WB_TRACE_EN adds the pc inputs and the difftest commit outputs.
interface wb_arbiter_if;
  import wb_arbiter_pkg::*;

  logic               pipe_valid;
  logic [4:0]         pipe_rd;
  logic [31:0]        pipe_data;
  logic               pipe_stall;

  logic               ll_valid;
  logic               ll_ready;
  logic [4:0]         ll_rd;
  logic [31:0]        ll_data;

  logic               we;
  logic [4:0]         rd_index;
  logic [31:0]        rd_write;
  logic [REG_NUM-1:0] ll_busy;

`ifdef WB_TRACE_EN
  logic [31:0]        pipe_pc;
  logic [31:0]        ll_pc;
  logic [31:0]        debug_wb_pc;
  logic               debug_wb_we;
  logic [4:0]         debug_wb_rd;
  logic [31:0]        debug_wb_data;
`endif

  modport slave (
`ifdef WB_TRACE_EN
    input  pipe_pc, ll_pc,
    output debug_wb_pc, debug_wb_we, debug_wb_rd, debug_wb_data,
`endif
    input  pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
    output pipe_stall, ll_ready, we, rd_index, rd_write, ll_busy
  );

  modport master (
`ifdef WB_TRACE_EN
    output pipe_pc, ll_pc,
    input  debug_wb_pc, debug_wb_we, debug_wb_rd, debug_wb_data,
`endif
    output pipe_valid, pipe_rd, pipe_data, ll_valid, ll_rd, ll_data,
    input  pipe_stall, ll_ready, we, rd_index, rd_write, ll_busy
  );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO for long-latency writeback requests.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
// Per-slot valid flags and destination indices are exported so the parent
// can build its pending-destination mask without a second copy of state.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  wb_req_t               din_i,
  output wb_req_t               head_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [DEPTH-1:0]      entry_valid_o,
  output logic [DEPTH-1:0][4:0] entry_rd_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count;
  logic        do_push;
  logic        do_pop;
  wb_req_t     mem_q [DEPTH];

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count   = wr_ptr_q - rd_ptr_q;

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

  assign head_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers; resetting them alone empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write port.
  // NOTE: storage has no reset; slot contents are only trusted when the
  // pointers mark them valid, so clearing the pointers is enough.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end
  end

  // A slot is occupied when its distance from the read index is below count.
  always_comb begin
    entry_valid_o = '0;
    entry_rd_o    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid_o[i] = ({1'b0, AW'(i) - rd_ptr_q[AW-1:0]} < count);
      entry_rd_o[i]    = mem_q[i].rd;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: owns the single register-file write port and merges the
// in-order pipeline writeback with queued long-latency results.
// r0 writes are dropped here because the register file does not guard r0.
// A starvation counter forces a pipe stall so a queued result always drains.
// Optional build macro: WB_TRACE_EN (pc tracking and difftest commit port).
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_LIMIT) + 1;

  wb_req_t               ll_req;
  wb_req_t               head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [DEPTH-1:0]      entry_valid;
  logic [DEPTH-1:0][4:0] entry_rd;
  logic                  pipe_present;
  logic                  stall;
  wb_sel_e               sel;
  logic [REG_NUM-1:0]    ll_busy;

  logic [SW-1:0]         starve_q, starve_d;
  logic                  we_q, we_d;
  logic [4:0]            rd_index_q, rd_index_d;
  logic [31:0]           rd_write_q, rd_write_d;

`ifdef WB_TRACE_EN
  logic                  dbg_we_q, dbg_we_d;
  logic [31:0]           dbg_pc_q, dbg_pc_d;
  logic [4:0]            dbg_rd_q, dbg_rd_d;
  logic [31:0]           dbg_data_q, dbg_data_d;
`endif

  // Readiness tracks occupancy only, so producers never see a comb loop.
  assign bus.ll_ready = !fifo_full;
  // r0 results are acknowledged but never occupy a slot.
  assign push = bus.ll_valid && !fifo_full && (bus.ll_rd != R0);

  // The head has waited its limit: upstream must hold for one cycle.
  assign stall          = !fifo_empty && (starve_q == SW'(STARVE_LIMIT - 1));
  assign bus.pipe_stall = stall;

`ifdef WB_TRACE_EN
  // Trace build: an r0 pipe result still takes the slot so it can be
  // reported as a commit, but it never raises we.
  assign pipe_present = bus.pipe_valid;
`else
  assign pipe_present = bus.pipe_valid && (bus.pipe_rd != R0);
`endif

  // Pack the long-latency inputs into a FIFO record.
  always_comb begin
    ll_req      = '0;
    ll_req.rd   = bus.ll_rd;
    ll_req.data = bus.ll_data;
`ifdef WB_TRACE_EN
    ll_req.pc   = bus.ll_pc;
`endif
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push),
    .pop_i         (pop),
    .din_i         (ll_req),
    .head_o        (head),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .entry_valid_o (entry_valid),
    .entry_rd_o    (entry_rd)
  );

  // Priority select: forced drain, then pipe, then opportunistic drain.
  always_comb begin
    sel = SEL_NONE;
    if (stall) begin
      sel = SEL_LL;
    end else if (pipe_present) begin
      sel = SEL_PIPE;
    end else if (!fifo_empty) begin
      sel = SEL_LL;
    end
  end

  assign pop = (sel == SEL_LL);

  // Starvation counter: runs only while the head sits there unserved.
  always_comb begin
    starve_d = starve_q + 1'b1;
    if (fifo_empty || pop) begin
      starve_d = '0;
    end
  end

  // Next value of the registered write port.
  // NOTE: every signal gets a default before the case so that no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    we_d       = 1'b0;
    rd_index_d = rd_index_q;
    rd_write_d = rd_write_q;
`ifdef WB_TRACE_EN
    dbg_we_d   = 1'b0;
    dbg_pc_d   = dbg_pc_q;
    dbg_rd_d   = dbg_rd_q;
    dbg_data_d = dbg_data_q;
`endif
    case (sel)
      SEL_PIPE: begin
        we_d       = (bus.pipe_rd != R0);
        rd_index_d = bus.pipe_rd;
        rd_write_d = bus.pipe_data;
`ifdef WB_TRACE_EN
        dbg_we_d   = 1'b1;
        dbg_pc_d   = bus.pipe_pc;
        dbg_rd_d   = bus.pipe_rd;
        dbg_data_d = bus.pipe_data;
`endif
      end
      SEL_LL: begin
        we_d       = 1'b1;
        rd_index_d = head.rd;
        rd_write_d = head.data;
`ifdef WB_TRACE_EN
        dbg_we_d   = 1'b1;
        dbg_pc_d   = head.pc;
        dbg_rd_d   = head.rd;
        dbg_data_d = head.data;
`endif
      end
      default: ;
    endcase
  end

  // Output stage and starvation counter registers.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples its inputs from before the edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q       <= 1'b0;
      rd_index_q <= '0;
      rd_write_q <= '0;
      starve_q   <= '0;
    end else begin
      we_q       <= we_d;
      rd_index_q <= rd_index_d;
      rd_write_q <= rd_write_d;
      starve_q   <= starve_d;
    end
  end

`ifdef WB_TRACE_EN
  // Difftest commit port, registered in step with we.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbg_we_q   <= 1'b0;
      dbg_pc_q   <= '0;
      dbg_rd_q   <= '0;
      dbg_data_q <= '0;
    end else begin
      dbg_we_q   <= dbg_we_d;
      dbg_pc_q   <= dbg_pc_d;
      dbg_rd_q   <= dbg_rd_d;
      dbg_data_q <= dbg_data_d;
    end
  end

  assign bus.debug_wb_we   = dbg_we_q;
  assign bus.debug_wb_pc   = dbg_pc_q;
  assign bus.debug_wb_rd   = dbg_rd_q;
  assign bus.debug_wb_data = dbg_data_q;
`endif

  // Pending-destination mask, derived straight from the occupied slots so a
  // bit stays set while any queued entry still targets that register.
  always_comb begin
    ll_busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) begin
        ll_busy[entry_rd[i]] = 1'b1;
      end
    end
    ll_busy[R0] = 1'b0;
  end

  assign bus.ll_busy  = ll_busy;
  assign bus.we       = we_q;
  assign bus.rd_index = rd_index_q;
  assign bus.rd_write = rd_write_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter (DEPTH=4, STARVE_LIMIT=8).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  wb_arbiter_if bus ();

  wb_arbiter #(
    .DEPTH        (4),
    .STARVE_LIMIT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef WB_TRACE_EN
  initial begin
    bus.pipe_pc = '0;
    bus.ll_pc   = '0;
  end
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
    bus.pipe_valid = pv;
    bus.pipe_rd    = prd;
    bus.pipe_data  = pdata;
    bus.ll_valid   = lv;
    bus.ll_rd      = lrd;
    bus.ll_data    = ldata;
  endtask

  // Issue-side WAW rule: a presented pipe destination must not be pending.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.pipe_valid === 1'b1 && bus.pipe_rd != R0)
      check("waw_guard", 32'(bus.ll_busy[bus.pipe_rd]), 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    step();

    // Reset state
    check("rst_we",       32'(bus.we),         32'd0);
    check("rst_rd_index", 32'(bus.rd_index),   32'd0);
    check("rst_rd_write", bus.rd_write,        32'd0);
    check("rst_stall",    32'(bus.pipe_stall), 32'd0);
    check("rst_ready",    32'(bus.ll_ready),   32'd1);
    check("rst_busy",     bus.ll_busy,         32'd0);
    rst = 1'b0;

    // Pipe only: one-cycle registered write
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    step();
    check("pipe_we",    32'(bus.we),       32'd1);
    check("pipe_rd",    32'(bus.rd_index), 32'd5);
    check("pipe_data",  bus.rd_write,      32'h1234);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check("pipe_we_drop", 32'(bus.we), 32'd0);

    // r0 suppression on both sources
    drive(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hAAAA);
    check("r0_ll_ready", 32'(bus.ll_ready), 32'd1);
    step();
    check("r0_we",   32'(bus.we),  32'd0);
    check("r0_busy", bus.ll_busy,  32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check("r0_we_late",   32'(bus.we), 32'd0);
    check("r0_busy_late", bus.ll_busy, 32'd0);

    // Collision: pipe wins, ll waits for the first free slot
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd7, 32'h77);
    step();
    check("col_pipe_we",   32'(bus.we),       32'd1);
    check("col_pipe_rd",   32'(bus.rd_index), 32'd3);
    check("col_pipe_data", bus.rd_write,      32'h33);
    check("col_busy",      bus.ll_busy,       32'h80);
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0);
    step();
    check("col_pipe2_rd",  32'(bus.rd_index), 32'd4);
    check("col_busy_hold", bus.ll_busy,       32'h80);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check("col_ll_we",      32'(bus.we),       32'd1);
    check("col_ll_rd",      32'(bus.rd_index), 32'd7);
    check("col_ll_data",    bus.rd_write,      32'h77);
    check("col_busy_clear", bus.ll_busy,       32'd0);
    step();
    check("col_idle_we", 32'(bus.we), 32'd0);

    // Full FIFO: four pushes under continuous pipe traffic
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 5'(9 + k), 32'h1000 + 32'(k), 1'b1, 5'(k), 32'h100 + 32'(k));
      step();
      check("full_pipe_rd", 32'(bus.rd_index), 32'(9 + k));
      check("full_ready",   32'(bus.ll_ready), 32'(k < 4 ? 1 : 0));
    end
    check("full_busy", bus.ll_busy, 32'h1E);
    drive(1'b1, 5'd14, 32'h1005, 1'b1, 5'd5, 32'h105);
    step();
    check("full_pipe_last", 32'(bus.rd_index), 32'd14);
    check("full_held_ready", 32'(bus.ll_ready), 32'd0);
    check("full_busy_hold",  bus.ll_busy,       32'h1E);
    // Pop while full: the held offer is still refused this cycle
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h105);
    step();
    check("drain1_rd",    32'(bus.rd_index), 32'd1);
    check("drain1_data",  bus.rd_write,      32'h101);
    check("drain1_ready", 32'(bus.ll_ready), 32'd1);
    check("drain1_busy",  bus.ll_busy,       32'h1C);
    // Now accepted alongside a pop: occupancy unchanged
    step();
    check("drain2_rd",    32'(bus.rd_index), 32'd2);
    check("drain2_busy",  bus.ll_busy,       32'h38);
    check("drain2_ready", 32'(bus.ll_ready), 32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check("drain3_rd", 32'(bus.rd_index), 32'd3);
    step();
    check("drain4_rd", 32'(bus.rd_index), 32'd4);
    step();
    check("drain5_we",   32'(bus.we),       32'd1);
    check("drain5_rd",   32'(bus.rd_index), 32'd5);
    check("drain5_data", bus.rd_write,      32'h105);
    step();
    check("drain_idle_we", 32'(bus.we), 32'd0);
    check("drain_busy",    bus.ll_busy, 32'd0);

    // Starvation: head waits 8 cycles, then a forced stall drains it
    drive(1'b1, 5'd20, 32'h2020, 1'b1, 5'd9, 32'h99);
    step();
    check("starve_first_rd", 32'(bus.rd_index),   32'd20);
    check("starve_stall_0",  32'(bus.pipe_stall), 32'd0);
    drive(1'b1, 5'd20, 32'h2020, 1'b0, 5'd0, 32'd0);
    for (int k = 1; k <= 7; k++) begin
      step();
      check("starve_stall", 32'(bus.pipe_stall), 32'(k == 7 ? 1 : 0));
      check("starve_pipe_rd", 32'(bus.rd_index), 32'd20);
    end
    step();
    check("starve_ll_we",   32'(bus.we),         32'd1);
    check("starve_ll_rd",   32'(bus.rd_index),   32'd9);
    check("starve_ll_data", bus.rd_write,        32'h99);
    check("starve_release", 32'(bus.pipe_stall), 32'd0);
    step();
    check("starve_resume_rd", 32'(bus.rd_index),   32'd20);
    check("starve_no_stall",  32'(bus.pipe_stall), 32'd0);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();
    check("starve_idle_we", 32'(bus.we), 32'd0);

    // Async reset with three queued entries
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'(21 + k), 32'h3000 + 32'(k), 1'b1, 5'(11 + k), 32'h200 + 32'(k));
      step();
    end
    check("ar_busy_pre",  bus.ll_busy,       32'h3800);
    check("ar_ready_pre", 32'(bus.ll_ready), 32'd1);
    check("ar_we_pre",    32'(bus.we),       32'd1);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #3;
    rst = 1'b1;
    #1;
    check("ar_we",       32'(bus.we),         32'd0);
    check("ar_busy",     bus.ll_busy,         32'd0);
    check("ar_ready",    32'(bus.ll_ready),   32'd1);
    check("ar_stall",    32'(bus.pipe_stall), 32'd0);
    check("ar_rd_index", 32'(bus.rd_index),   32'd0);
    step();
    rst = 1'b0;
    step();
    check("ar_post_we1", 32'(bus.we), 32'd0);
    step();
    check("ar_post_we2", 32'(bus.we),  32'd0);
    check("ar_post_busy", bus.ll_busy, 32'd0);
    drive(1'b1, 5'd6, 32'hABCD, 1'b0, 5'd0, 32'd0);
    step();
    check("ar_new_rd",   32'(bus.rd_index), 32'd6);
    check("ar_new_data", bus.rd_write,      32'hABCD);
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
